pipelined_csel_adder: RTL and testbench
=======================================

// Module: pipelined_csel_adder
// PURPOSE
//  Parametrised, pipelined carry-select adder/subtractor. Successor to the 8-bit
//  combinational 2-bit-segment adder.
//  - WIDTH is split into SEG-bit segments.
//  - One segment's carry is resolved per pipeline stage.
//  - Throughput is one operation per clock.
//  - valid/ready handshake on both sides, so it drops into streaming datapaths.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits; must be a multiple of SEG
//  SEG     4  segment width in bits; 1 <= SEG <= WIDTH; NSEG = WIDTH/SEG stages
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      input operation present
//  in_ready   out  1      block can accept an operation this cycle
//  din_a      in   WIDTH  operand A
//  din_b      in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: add, 1: subtract
//  out_valid  out  1      result present
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry-out; in sub mode 1 = no borrow
//  ovf        out  1      signed (two's complement) overflow
// BEHAVIOUR
//  - Arithmetic:
//    - sub=0: {cout,sum} = A + B + cin.
//    - sub=1: {cout,sum} = A + ~B + !cin, i.e. A - B - cin.
//    - ovf = carry into MSB XOR carry out of MSB.
//    - All widths are exact; no truncation before the final cout.
//  - Accept: a transfer occurs when in_valid && in_ready. Operands, cin and sub
//    are captured at that edge.
//  - Stages:
//    - Stage k (k = 0..NSEG-1) forms both candidate segment sums (carry 0 and
//      carry 1) for segment k.
//    - It selects one with the carry registered from stage k-1 (stage 0 uses
//      the effective cin).
//    - It passes along the resolved low bits, the unresolved high operand
//      bits, its carry and valid.
//  - Latency: NSEG cycles from accept to out_valid, with no stall.
//    - SEG=WIDTH gives latency 1 (single registered stage).
//  - Stall:
//    - stall = out_valid && !out_ready.
//    - in_ready = !stall.
//    - While stalled, every stage register (data and valid) holds. Nothing is
//      lost or duplicated.
//  - Bubbles: an empty stage (valid=0) advances normally. No compaction is
//    required.
//  - Output hold: sum/cout/ovf stay stable while out_valid && !out_ready.
//  - Ordering: results leave strictly in acceptance order.
//  - Simultaneous events:
//    - When out_ready=1, the result is consumed and a new input is accepted on
//      the same edge.
//    - Full-rate streaming sustains 1 op/cycle.
//  - Reset (sync, active-high):
//    - All stage valid bits -> 0, out_valid -> 0.
//    - sum -> 0, cout -> 0, ovf -> 0.
//    - in_ready -> 1 in the cycle after rst deasserts (it depends on out_valid).
//    - Reset mid-operation discards all in-flight ops. No partial result is ever
//      presented.
//  - Wrap-around: overflow wraps modulo 2^WIDTH. cout/ovf report it; no
//    saturation.
// TESTING  (WIDTH=16, SEG=4 unless noted; latency 4)
//  1. Add with carry-out: A=0xFFFF, B=0x0001, cin=0, sub=0 -> 4 cycles later
//     sum=0x0000, cout=1, ovf=0.
//  2. Signed overflow: A=0x7FFF, B=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0,
//     ovf=1.
//  3. Subtract with borrow: A=0x0005, B=0x0007, cin=0, sub=1 -> sum=0xFFFE,
//     cout=0, ovf=0. Same with A=0x0007, B=0x0005 -> sum=0x0002, cout=1.
//  4. Backpressure: stream 8 back-to-back ops while out_ready toggles
//     1,0,0,1,... -> all 8 results in order, none lost or duplicated, and
//     outputs stable during stalls.
//  5. Reset mid-stream: rst high for 1 cycle with 3 ops in flight -> out_valid=0
//     next cycle and zero stale results afterwards; a new op gives the correct
//     result after 4 cycles.
//  6. Randomised: 10k random ops with random sub/cin/valid/ready against a
//     behavioural model; repeat with SEG=1 (latency 16) and SEG=16
//     (latency 1).

Source files
------------

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one SEG-bit segment's carry resolved per stage,
// valid/ready handshake with whole-pipe freeze on output backpressure.
module pipelined_csel_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SEG   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din_a,
   input  logic [WIDTH-1:0] din_b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NSEG = WIDTH / SEG;

   if (SEG == 0 || SEG > WIDTH || (WIDTH % SEG) != 0) begin : g_bad_param
      $error("pipelined_csel_adder: WIDTH must be a non-zero multiple of SEG");
   end

   // Stage registers; index k holds the state after segment k has been resolved.
   logic [WIDTH-1:0] a_q [NSEG];
   logic [WIDTH-1:0] b_q [NSEG];
   logic [WIDTH-1:0] s_q [NSEG];
   logic             c_q [NSEG];
   logic             v_q [NSEG];
   logic             ovf_q;

   // Per-stage inputs (from the port for stage 0, from the previous register otherwise).
   logic [WIDTH-1:0] a_src [NSEG];
   logic [WIDTH-1:0] b_src [NSEG];
   logic [WIDTH-1:0] s_src [NSEG];
   logic             c_src [NSEG];
   logic             v_src [NSEG];

   logic [SEG:0]     cand0 [NSEG];
   logic [SEG:0]     cand1 [NSEG];
   logic [WIDTH-1:0] s_nxt [NSEG];
   logic             c_nxt [NSEG];
   logic             ovf_nxt;

   logic stall;
   logic accept;

   assign stall     = v_q[NSEG-1] && !out_ready;
   assign in_ready  = !stall;
   assign accept    = in_valid && in_ready;

   assign out_valid = v_q[NSEG-1];
   assign sum       = s_q[NSEG-1];
   assign cout      = c_q[NSEG-1];
   assign ovf       = ovf_q;

   // Subtraction is folded in at entry: B is inverted and the carry-in becomes !borrow.
   always_comb begin
      a_src[0] = din_a;
      b_src[0] = sub ? ~din_b : din_b;
      s_src[0] = '0;
      c_src[0] = cin ^ sub;
      v_src[0] = accept;
      for (int k = 1; k < NSEG; k++) begin
         a_src[k] = a_q[k-1];
         b_src[k] = b_q[k-1];
         s_src[k] = s_q[k-1];
         c_src[k] = c_q[k-1];
         v_src[k] = v_q[k-1];
      end
   end

   // Both candidate sums per segment, selected by the carry resolved in the stage before.
   always_comb begin
      for (int k = 0; k < NSEG; k++) begin
         cand0[k] = {1'b0, a_src[k][k*SEG +: SEG]} + {1'b0, b_src[k][k*SEG +: SEG]};
         cand1[k] = cand0[k] + {{SEG{1'b0}}, 1'b1};
         s_nxt[k] = s_src[k];
         s_nxt[k][k*SEG +: SEG] = c_src[k] ? cand1[k][SEG-1:0] : cand0[k][SEG-1:0];
         c_nxt[k] = c_src[k] ? cand1[k][SEG] : cand0[k][SEG];
      end
      // Carry into the MSB is recovered as a^b^sum at that bit position.
      ovf_nxt = c_nxt[NSEG-1] ^ (a_src[NSEG-1][WIDTH-1] ^ b_src[NSEG-1][WIDTH-1]
                                 ^ s_nxt[NSEG-1][WIDTH-1]);
   end

   // Whole pipe holds on stall so the presented result and everything behind it stay put.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSEG; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
            v_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (!stall) begin
         for (int k = 0; k < NSEG; k++) begin
            a_q[k] <= a_src[k];
            b_q[k] <= b_src[k];
            s_q[k] <= s_nxt[k];
            c_q[k] <= c_nxt[k];
            v_q[k] <= v_src[k];
         end
         ovf_q <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder (WIDTH=16, SEG=4): directed vector table, backpressure,
// mid-stream reset and a short randomised stream against a behavioural model.
module tb_pipelined_csel_adder;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned SEG   = 4;
   localparam int          LAT   = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] din_a;
   logic [WIDTH-1:0] din_b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] e_sum;
      logic        e_cout;
      logic        e_ovf;
   } vec_t;

   typedef struct packed {
      logic [15:0] s;
      logic        c;
      logic        o;
   } res_t;

   pipelined_csel_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .din_a(din_a), .din_b(din_b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic c, input logic s);
      res_t        m;
      logic [15:0] be;
      logic [16:0] r;
      be  = s ? ~b : b;
      r   = {1'b0, a} + {1'b0, be} + 17'(s ? !c : c);
      m.s = r[15:0];
      m.c = r[16];
      m.o = (a[15] == be[15]) && (r[15] != a[15]);
      return m;
   endfunction

   // Single isolated op: checks latency from the accept edge and the result.
   task automatic run_op(input string tag, input vec_t v);
      int lat;
      bit got;
      @(negedge clk);
      din_a = v.a; din_b = v.b; cin = v.cin; sub = v.sub;
      in_valid = 1'b1; out_ready = 1'b1;
      #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      got = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if (out_valid) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, got ? 32'(lat) : 32'd0, 32'(LAT));
      chk({tag, "_sum"},  32'(sum),  32'(v.e_sum));
      chk({tag, "_cout"}, 32'(cout), 32'(v.e_cout));
      chk({tag, "_ovf"},  32'(ovf),  32'(v.e_ovf));
   endtask

   // Streams n ops; rnd=0 uses ready pattern 1,0,0 and continuous valid, rnd=1 randomises.
   task automatic stream(input string tag, input int n, input bit rnd);
      res_t        q[$];
      res_t        e;
      int          sent = 0;
      int          rcvd = 0;
      int          cyc  = 0;
      bit          held = 1'b0;
      logic [15:0] hs;
      logic        hc;
      logic        ho;
      while (rcvd < n && cyc < 4000) begin
         @(negedge clk);
         out_ready = rnd ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
         if (sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
            in_valid = 1'b1;
            if (rnd) begin
               din_a = 16'($urandom); din_b = 16'($urandom);
               cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            end else begin
               din_a = 16'(sent * 32'h1357 + 32'h0F0F);
               din_b = 16'(sent * 32'h2468 + 32'h00F1);
               cin = 1'(sent >> 1); sub = 1'(sent);
            end
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (held) begin
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_sum"},   32'(sum),  32'(hs));
            chk({tag, "_hold_cout"},  32'(cout), 32'(hc));
            chk({tag, "_hold_ovf"},   32'(ovf),  32'(ho));
         end
         held = out_valid && !out_ready;
         hs = sum; hc = cout; ho = ovf;
         chk({tag, "_in_ready"}, 32'(in_ready), 32'(!(out_valid && !out_ready)));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk({tag, "_spurious_out"}, 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk($sformatf("%s_r%0d_sum", tag, rcvd),  32'(sum),  32'(e.s));
               chk($sformatf("%s_r%0d_cout", tag, rcvd), 32'(cout), 32'(e.c));
               chk($sformatf("%s_r%0d_ovf", tag, rcvd),  32'(ovf),  32'(e.o));
            end
            rcvd++;
         end
         if (in_valid && in_ready) begin
            q.push_back(model(din_a, din_b, cin, sub));
            sent++;
         end
         cyc++;
      end
      chk({tag, "_count"}, 32'(rcvd), 32'(n));
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1 chk({tag, "_drained"}, 32'(out_valid), 32'd0);
   endtask

   vec_t vecs[11];

   initial begin
      int stale;

      // A, B, cin, sub, sum, cout, ovf (hand-computed)
      vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[3]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
      vecs[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
      vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      vecs[8]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      din_a = '0; din_b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum",       32'(sum),       32'd0);
      chk("rst_cout",      32'(cout),      32'd0);
      chk("rst_ovf",       32'(ovf),       32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);

      for (int i = 0; i < 11; i++) run_op($sformatf("v%0d", i), vecs[i]);

      stream("bp", 8, 1'b0);

      // Reset with three ops in flight: nothing may emerge afterwards.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         din_a = 16'(32'h0100 * i + 32'h0011); din_b = 16'h0101;
         cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1 chk("midrst_out_valid", 32'(out_valid), 32'd0);
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      chk("midrst_no_stale", 32'(stale), 32'd0);
      run_op("midrst_new", vecs[6]);

      stream("rnd", 300, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
